// File: rtl/experiment_sequencer.sv
// Experiment sequencer: streams FRAME_COUNT operand frames through the datapath,
// waits LATENCY cycles per frame, captures results and returns them over valid/ready.
module experiment_sequencer #(
  parameter int unsigned FRAME_COUNT   = 16,
  parameter int unsigned OPERAND_COUNT = 2,
  parameter int unsigned OPERAND_WIDTH = 32,
  parameter int unsigned RESULT_COUNT  = 3,
  parameter int unsigned RESULT_WIDTH  = 32,
  parameter int unsigned LATENCY       = 4,
  parameter int unsigned OVF_IDX       = 0
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start,
  input  logic                                     abort,
  input  logic                                     frame_valid,
  output logic                                     frame_ready,
  input  logic [OPERAND_COUNT*OPERAND_WIDTH-1:0]   frame_data,
  output logic [OPERAND_COUNT*OPERAND_WIDTH-1:0]   exp_operands,
  input  logic [RESULT_COUNT*RESULT_WIDTH-1:0]     exp_results,
  output logic                                     res_valid,
  input  logic                                     res_ready,
  output logic [RESULT_COUNT*RESULT_WIDTH-1:0]     res_data,
  output logic [$clog2(FRAME_COUNT+1)-1:0]         frame_idx,
  output logic [$clog2(FRAME_COUNT+1)-1:0]         ovf_count,
  output logic                                     busy,
  output logic                                     done
);

  localparam int unsigned OPS_W  = OPERAND_COUNT * OPERAND_WIDTH;
  localparam int unsigned RES_W  = RESULT_COUNT * RESULT_WIDTH;
  localparam int unsigned IDX_W  = $clog2(FRAME_COUNT + 1);
  localparam int unsigned WAIT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned OVF_BIT = OVF_IDX * RESULT_WIDTH;

  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(FRAME_COUNT - 1);
  localparam logic [IDX_W-1:0]  OVF_MAX  = IDX_W'(FRAME_COUNT);
  localparam logic [WAIT_W-1:0] WAIT_END = WAIT_W'(LATENCY - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_APPLY   = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  ovf_q, ovf_d;
  logic [OPS_W-1:0]  ops_q, ops_d;
  logic [RES_W-1:0]  res_q, res_d;
  logic              frame_ready_q, frame_ready_d;
  logic              res_valid_q, res_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Next-state and datapath register updates; abort outranks every handshake.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;
    ops_d   = ops_q;
    res_d   = res_q;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_LOAD;
          idx_d   = '0;
          ovf_d   = '0;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (frame_valid) begin
          ops_d   = frame_data;
          wait_d  = '0;
          state_d = S_APPLY;
        end
      end
      S_APPLY: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (wait_q == WAIT_END) begin
          res_d   = exp_results;
          state_d = S_CAPTURE;
          if (exp_results[OVF_BIT] && (ovf_q != OVF_MAX)) begin
            ovf_d = ovf_q + IDX_W'(1);
          end
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_CAPTURE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (res_ready) begin
          if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_LOAD;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Handshake/status flags are registered copies of the upcoming state.
    frame_ready_d = (state_d == S_LOAD);
    res_valid_d   = (state_d == S_CAPTURE);
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wait_q        <= '0;
      idx_q         <= '0;
      ovf_q         <= '0;
      ops_q         <= '0;
      res_q         <= '0;
      frame_ready_q <= 1'b0;
      res_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      idx_q         <= idx_d;
      ovf_q         <= ovf_d;
      ops_q         <= ops_d;
      res_q         <= res_d;
      frame_ready_q <= frame_ready_d;
      res_valid_q   <= res_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign frame_ready  = frame_ready_q;
  assign res_valid    = res_valid_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign exp_operands = ops_q;
  assign res_data     = res_q;
  assign frame_idx    = idx_q;
  assign ovf_count    = ovf_q;

endmodule

// File: tb/tb_experiment_sequencer.sv
// Directed bench for experiment_sequencer with a pipelined complex-multiply datapath model.
module tb_experiment_sequencer;

  localparam int unsigned FC  = 4;
  localparam int unsigned LAT = 4;
  localparam int unsigned IW  = $clog2(FC + 1);

  logic          clk;
  logic          rst;
  logic          start;
  logic          abort;
  logic          frame_valid;
  logic          frame_ready;
  logic [63:0]   frame_data;
  logic [63:0]   exp_operands;
  logic [95:0]   exp_results;
  logic          res_valid;
  logic          res_ready;
  logic [95:0]   res_data;
  logic [IW-1:0] frame_idx;
  logic [IW-1:0] ovf_count;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  experiment_sequencer #(
    .FRAME_COUNT(FC), .OPERAND_COUNT(2), .OPERAND_WIDTH(32),
    .RESULT_COUNT(3), .RESULT_WIDTH(32), .LATENCY(LAT), .OVF_IDX(0)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_data(frame_data),
    .exp_operands(exp_operands), .exp_results(exp_results),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .frame_idx(frame_idx), .ovf_count(ovf_count), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Q2.14 complex multiply: r0 = overflow flag, r1 = {zi, zr}, r2 = raw real product.
  function automatic logic [95:0] dp_model(input logic [63:0] ops);
    logic signed [15:0] xr, xi, yr, yi;
    logic signed [33:0] pr, pi, zr, zi;
    logic ovf;
    xr = ops[15:0];  xi = ops[31:16];
    yr = ops[47:32]; yi = ops[63:48];
    pr = 34'(xr * yr) - 34'(xi * yi);
    pi = 34'(xr * yi) + 34'(xi * yr);
    zr = pr >>> 14;
    zi = pi >>> 14;
    ovf = (zr > 34'sd32767) || (zr < -34'sd32768) || (zi > 34'sd32767) || (zi < -34'sd32768);
    return {pr[31:0], zi[15:0], zr[15:0], 31'd0, ovf};
  endfunction

  logic [95:0] pipe_q [LAT-1];
  initial for (int i = 0; i < LAT - 1; i++) pipe_q[i] = '0;
  always @(posedge clk) begin
    pipe_q[0] <= dp_model(exp_operands);
    for (int i = 1; i < LAT - 1; i++) pipe_q[i] <= pipe_q[i-1];
  end
  assign exp_results = pipe_q[LAT-2];

  // Operand frames {Yi, Yr, Xi, Xr} and hand-computed result vectors {r2, r1, r0}.
  localparam logic [63:0] FR_A = 64'h0000_4000_0000_4000;
  localparam logic [95:0] EX_A = 96'h10000000_00004000_00000000;
  localparam logic [63:0] FR_B = 64'h2000_4000_4000_2000;
  localparam logic [95:0] EX_B = 96'h00000000_50000000_00000000;
  localparam logic [63:0] FR_C = 64'h4000_4000_0000_C000;
  localparam logic [95:0] EX_C = 96'hF0000000_C000C000_00000000;
  localparam logic [63:0] FR_O = 64'h0000_7FFF_0000_7FFF;
  localparam logic [95:0] EX_O = 96'h3FFF0001_0000FFFC_00000001;

  logic [63:0] fr_tbl [4];
  logic [95:0] ex_tbl [4];

  task automatic check_val(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_frame(input string tag, input logic [63:0] d);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = frame_ready;
    end
    if (!seen) check_val({tag, "_rdy_tmo"}, 96'(frame_ready), 96'(1));
    frame_data  = d;
    frame_valid = 1'b1;
    @(posedge clk); #1;
    frame_valid = 1'b0;
  endtask

  task automatic recv_result(input string tag, input logic [95:0] exp, input int hold, input bit release_it);
    bit seen = 1'b0;
    for (int i = 0; i < 2 * LAT + 6 && !seen; i++) begin
      @(negedge clk);
      seen = res_valid;
    end
    if (!seen) check_val({tag, "_vld_tmo"}, 96'(res_valid), 96'(1));
    check_val({tag, "_data"}, res_data, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_val({tag, "_hold_vld"}, 96'(res_valid), 96'(1));
      check_val({tag, "_hold_data"}, res_data, exp);
      check_val({tag, "_hold_frdy"}, 96'(frame_ready), 96'(0));
    end
    if (release_it) begin
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_ops"}, 96'(exp_operands), 96'(0));
    check_val({tag, "_res"}, res_data, 96'(0));
    check_val({tag, "_flags"}, 96'({frame_ready, res_valid, busy, done}), 96'(0));
    check_val({tag, "_cnts"}, 96'({frame_idx, ovf_count}), 96'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, r, done_cnt, done_edge, dn;
    bit acc, seen;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    frame_valid = 1'b0; res_ready = 1'b0; frame_data = '0;
    fr_tbl[0] = FR_A; fr_tbl[1] = FR_B; fr_tbl[2] = FR_C; fr_tbl[3] = FR_O;
    ex_tbl[0] = EX_A; ex_tbl[1] = EX_B; ex_tbl[2] = EX_C; ex_tbl[3] = EX_O;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Full run with valid/ready tied high; done_edge is the edge that samples done.
    frame_valid = 1'b1; res_ready = 1'b1; frame_data = fr_tbl[0];
    k = 0; r = 0; done_cnt = 0; done_edge = 0;
    pulse_start();
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) begin done_cnt++; done_edge = n + 1; end
      if (res_valid && r < 4) begin check_val("t1_res", res_data, ex_tbl[r]); r++; end
      acc = frame_ready;
      @(posedge clk); #1;
      if (acc && k < 3) begin k++; frame_data = fr_tbl[k]; end
    end
    frame_valid = 1'b0; res_ready = 1'b0;
    check_val("t1_nres", 96'(r), 96'(4));
    check_val("t1_done_cnt", 96'(done_cnt), 96'(1));
    check_val("t1_done_edge", 96'(done_edge), 96'(6 * FC + 1));
    check_val("t1_idle", 96'({busy, frame_ready, res_valid}), 96'(0));
    check_val("t1_idx", 96'(frame_idx), 96'(3));
    check_val("t1_ovf", 96'(ovf_count), 96'(1));

    // Exact capture latency and operand hold during APPLY.
    pulse_start();
    @(negedge clk);
    check_val("t2_frdy", 96'(frame_ready), 96'(1));
    frame_data = FR_A; frame_valid = 1'b1;
    @(posedge clk); #1;
    frame_valid = 1'b0; frame_data = FR_B;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("t2_ops", 96'(exp_operands), 96'(FR_A));
      check_val("t2_rv", 96'(res_valid), 96'(i == 4));
    end
    check_val("t2_res", res_data, EX_A);

    // Back-pressure in CAPTURE.
    recv_result("t3", EX_A, 10, 1'b1);

    // Start while busy is ignored; reset in CAPTURE clears everything.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_val("t6_start_busy", 96'({busy, frame_ready, frame_idx}), 96'({1'b1, 1'b1, 3'd1}));
    send_frame("t6", FR_B);
    recv_result("t6", EX_B, 0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_all_zero("t6_rst");
    @(negedge clk);
    rst = 1'b0;

    // Overflow counting across a run.
    pulse_start();
    send_frame("t4f0", FR_A); recv_result("t4f0", EX_A, 0, 1'b1);
    send_frame("t4f1", FR_O); recv_result("t4f1", EX_O, 0, 1'b1);
    send_frame("t4f2", FR_C); recv_result("t4f2", EX_C, 0, 1'b1);
    send_frame("t4f3", FR_O); recv_result("t4f3", EX_O, 0, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    check_val("t4_done", 96'({seen, busy}), 96'({1'b1, 1'b1}));
    check_val("t4_ovf", 96'(ovf_count), 96'(2));
    pulse_start();
    check_val("t4_restart", 96'({frame_idx, ovf_count}), 96'(0));

    // Abort in APPLY of frame 2.
    send_frame("t5f0", FR_A); recv_result("t5f0", EX_A, 0, 1'b1);
    send_frame("t5f1", FR_O); recv_result("t5f1", EX_O, 0, 1'b1);
    send_frame("t5f2", FR_C);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check_val("t5_abort_flags", 96'({busy, frame_ready, res_valid}), 96'(0));
    check_val("t5_abort_cnts", 96'({frame_idx, ovf_count}), 96'({3'd2, 3'd1}));
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    check_val("t5_no_done", 96'(dn), 96'(0));
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check_val("t5_abort_wins", 96'(busy), 96'(0));
    pulse_start();
    check_val("t5_restart", 96'({busy, frame_ready, frame_idx}), 96'({1'b1, 1'b1, 3'd0}));
    @(negedge clk);
    frame_data = FR_B; frame_valid = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    frame_valid = 1'b0; abort = 1'b0;
    check_val("t5_abort_hs", 96'(busy), 96'(0));
    check_val("t5_abort_ops", 96'(exp_operands), 96'(FR_C));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
